cmp_share_arb: RTL and testbench

- Shares one IN-bit magnitude comparator between N requesters using round-robin arbitration and a req/done handshake.
- Each requester presents an operand pair and holds req until its one-cycle done pulse; results are broadcast on common g/l/e lines qualified by done.
- Sits between the datapath clients (sort/min-max engines) and the single comparator resource, so the comparator is not duplicated per client.

---
 rtl/cmp_share_arb_pkg.sv | 41 ++++
 rtl/cmp_share_arb_if.sv | 27 ++
 rtl/cmp_share_arb_mag_cmp.sv | 24 ++
 rtl/cmp_share_arb.sv | 120 ++++++++++++
 tb/tb_cmp_share_arb.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_share_arb_pkg.sv
// Shared types and helpers for the shared-comparator arbiter.
package cmp_share_arb_pkg;

    localparam int MAX_N = 8;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef logic [MAX_N-1:0] vec_t;
    typedef logic [PTR_W-1:0] idx_t;

    // Round-robin pick: first set bit of req scanning ptr, ptr+1, ... mod n.
    // Returns 0 when nothing is set; callers qualify with |req.
    function automatic idx_t rr_pick(input vec_t req, input idx_t ptr, input int n);
        idx_t pick;
        idx_t cand;
        bit   found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            cand = idx_t'((int'(ptr) + k) % n);
            if (k < n && !found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot encode an index into the widest supported vector.
    function automatic vec_t onehot(input idx_t idx);
        vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cmp_share_arb_if.sv
// Requester-side bus of the shared comparator: request/operands in, grant/done/result out.
interface cmp_share_arb_if #(
    parameter int N  = 4,
    parameter int IN = 16
) ();
    logic [N-1:0]    req;
    logic [N*IN-1:0] a_in;
    logic [N*IN-1:0] b_in;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [N-1:0]    done;
    logic            g;
    logic            l;
    logic            e;

    // Requester clients drive the operands and requests.
    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, g, l, e
    );

    // The arbiter consumes requests and returns grants and results.
    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, g, l, e
    );
endinterface

// File: rtl/cmp_share_arb_mag_cmp.sv
// Combinational IN-bit magnitude comparator; SIGNED selects two's-complement ordering.
module mag_cmp #(
    parameter int IN     = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic [IN-1:0] a,
    input  logic [IN-1:0] b,
    output logic          g,
    output logic          l,
    output logic          e
);
    // Ordering depends on signedness; equality does not.
    generate
        if (SIGNED) begin : g_signed
            assign g = $signed(a) > $signed(b);
            assign l = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign g = a > b;
            assign l = a < b;
        end
    endgenerate

    assign e = (a == b);
endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one magnitude comparator between N requesters.
// IDLE picks a winner and latches its operands; CMP evaluates and pulses done.
module cmp_share_arb
    import cmp_share_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int IN     = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    cmp_share_arb_if.slave bus
);
    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            busy_q, busy_d;
    idx_t            rr_ptr_q, rr_ptr_d;
    logic [IN-1:0]   a_r_q, a_r_d;
    logic [IN-1:0]   b_r_q, b_r_d;
    logic            g_q, g_d;
    logic            l_q, l_d;
    logic            e_q, e_d;

    vec_t            elig;
    idx_t            winner;
    logic [N-1:0]    win_oh;
    logic            cmp_g, cmp_l, cmp_e;

    mag_cmp #(
        .IN     (IN),
        .SIGNED (SIGNED)
    ) u_mag_cmp (
        .a (a_r_q),
        .b (b_r_q),
        .g (cmp_g),
        .l (cmp_l),
        .e (cmp_e)
    );

    // Next-state and output logic for the IDLE/CMP sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        rr_ptr_d = rr_ptr_q;
        a_r_d    = a_r_q;
        b_r_d    = b_r_q;
        g_d      = g_q;
        l_d      = l_q;
        e_d      = e_q;

        // A requester still holding req during its done cycle is masked out.
        elig   = vec_t'(bus.req & ~done_q);
        winner = rr_pick(elig, rr_ptr_q, N);
        win_oh = N'(onehot(winner));

        case (state_q)
            IDLE: begin
                done_d = '0;
                if (|elig) begin
                    a_r_d    = bus.a_in[int'(winner)*IN +: IN];
                    b_r_d    = bus.b_in[int'(winner)*IN +: IN];
                    gnt_d    = win_oh;
                    rr_ptr_d = idx_t'((int'(winner) + 1) % N);
                    state_d  = CMP;
                end else begin
                    gnt_d = '0;
                end
            end
            CMP: begin
                g_d     = cmp_g;
                l_d     = cmp_l;
                e_d     = cmp_e;
                done_d  = gnt_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CMP);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are reset too; they are a handful of flops, not a memory array.
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= '0;
            a_r_q    <= '0;
            b_r_q    <= '0;
            g_q      <= 1'b0;
            l_q      <= 1'b0;
            e_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            a_r_q    <= a_r_d;
            b_r_q    <= b_r_d;
            g_q      <= g_d;
            l_q      <= l_d;
            e_q      <= e_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.g    = g_q;
    assign bus.l    = l_q;
    assign bus.e    = e_q;
endmodule

// File: tb/tb_cmp_share_arb.sv
// Bench for cmp_share_arb: an unsigned and a signed instance share one stimulus
// stream and are compared each cycle against a transaction-level reference model.
module tb_cmp_share_arb;
    localparam int N  = 4;
    localparam int IN = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*IN-1:0] a_in;
    logic [N*IN-1:0] b_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_share_arb_if #(.N(N), .IN(IN)) if_u ();
    cmp_share_arb_if #(.N(N), .IN(IN)) if_s ();

    assign if_u.req  = req;
    assign if_u.a_in = a_in;
    assign if_u.b_in = b_in;
    assign if_s.req  = req;
    assign if_s.a_in = a_in;
    assign if_s.b_in = b_in;

    cmp_share_arb #(.N(N), .IN(IN), .SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .bus(if_u));
    cmp_share_arb #(.N(N), .IN(IN), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .bus(if_s));

    // Reference model state
    int          m_ptr;
    bit          m_busy;
    int          m_owner;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_done;
    logic [15:0] m_a, m_b;
    logic        m_ug, m_ul, m_ue;
    logic        m_sg, m_sl, m_se;

    task automatic model_reset();
        m_ptr = 0; m_busy = 0; m_owner = 0;
        m_gnt = '0; m_done = '0; m_a = '0; m_b = '0;
        m_ug = 0; m_ul = 0; m_ue = 0;
        m_sg = 0; m_sl = 0; m_se = 0;
    endtask

    function automatic int as_signed(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    // One clock edge of the specified behaviour, from pre-edge inputs.
    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        int ua, ub, sa, sb;
        if (m_busy) begin
            ua = int'(m_a); ub = int'(m_b);
            sa = as_signed(m_a); sb = as_signed(m_b);
            m_ug = (ua > ub); m_ul = (ua < ub); m_ue = (ua == ub);
            m_sg = (sa > sb); m_sl = (sa < sb); m_se = (sa == sb);
            m_done = '0;
            m_done[m_owner] = 1'b1;
            m_gnt  = '0;
            m_busy = 0;
        end else begin
            elig   = req & ~m_done;
            m_done = '0;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_owner = w;
                m_a     = a_in[w*IN +: IN];
                m_b     = b_in[w*IN +: IN];
                m_gnt   = '0;
                m_gnt[w] = 1'b1;
                m_ptr   = (w + 1) % N;
                m_busy  = 1;
            end else begin
                m_gnt = '0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":u_gnt"},  16'(if_u.gnt),  16'(m_gnt));
        chk({tag, ":u_done"}, 16'(if_u.done), 16'(m_done));
        chk({tag, ":u_busy"}, 16'(if_u.busy), 16'(m_busy));
        chk({tag, ":u_gle"},  16'({if_u.g, if_u.l, if_u.e}), 16'({m_ug, m_ul, m_ue}));
        chk({tag, ":s_gnt"},  16'(if_s.gnt),  16'(m_gnt));
        chk({tag, ":s_done"}, 16'(if_s.done), 16'(m_done));
        chk({tag, ":s_busy"}, 16'(if_s.busy), 16'(m_busy));
        chk({tag, ":s_gle"},  16'({if_s.g, if_s.l, if_s.e}), 16'({m_sg, m_sl, m_se}));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        a_in[i*IN +: IN] = a;
        b_in[i*IN +: IN] = b;
    endtask

    initial begin
        logic [15:0] ra;
        rst  = 1'b0;
        req  = '0;
        a_in = '0;
        b_in = '0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_outputs("reset");
        step("reset_hold");
        step("reset_hold");
        rst = 1'b0;

        // Single requester: 5 < 9 on requester 1
        set_ops(1, 16'd5, 16'd9);
        req = 4'b0010;
        step("single_grant");
        chk("single_gnt_const", 16'(if_u.gnt), 16'h0002);
        step("single_done");
        chk("single_done_const", 16'(if_u.done), 16'h0002);
        chk("single_l_const", 16'({if_u.g, if_u.l, if_u.e}), 16'h0002);
        req = '0;
        step("single_after");
        chk("single_done_clear", 16'(if_u.done), 16'h0000);

        // All four contending with equal operands
        for (int i = 0; i < N; i++) set_ops(i, 16'h00FF, 16'h00FF);
        req = 4'b1111;
        for (int c = 0; c < 16; c++) step("all_four");
        req = '0;
        for (int c = 0; c < 3; c++) step("all_four_drain");

        // Hold-over: requester 2 holds req through its done cycle
        set_ops(2, 16'h1234, 16'h1234);
        req = 4'b0100;
        step("hold_grant");
        step("hold_done");
        step("hold_masked");
        chk("hold_no_regrant", 16'(if_u.gnt), 16'h0000);
        for (int c = 0; c < 3; c++) step("hold_more");
        req = '0;
        for (int c = 0; c < 3; c++) step("hold_drain");

        // Hold-over with contention between 2 and 3
        set_ops(3, 16'h0001, 16'h0002);
        req = 4'b1100;
        for (int c = 0; c < 10; c++) step("hold_pair");
        req = '0;
        for (int c = 0; c < 3; c++) step("hold_pair_drain");

        // -1 vs 1: signed says less, unsigned says greater
        set_ops(0, 16'hFFFF, 16'h0001);
        req = 4'b0001;
        step("sign_grant");
        step("sign_done");
        chk("sign_signed_l", 16'({if_s.g, if_s.l, if_s.e}), 16'h0002);
        chk("sign_unsigned_g", 16'({if_u.g, if_u.l, if_u.e}), 16'h0004);
        req = '0;
        step("sign_after");

        // Reset while busy: abort, then re-arbitrate from index 0
        req = 4'b0100;
        step("rst_grant");
        chk("rst_busy_before", 16'(if_u.busy), 16'h0001);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("rst_async");
        chk("rst_gnt_zero", 16'(if_u.gnt), 16'h0000);
        chk("rst_busy_zero", 16'(if_u.busy), 16'h0000);
        set_ops(3, 16'h0010, 16'h0003);
        req = 4'b1001;
        step("rst_held");
        step("rst_held");
        rst = 1'b0;
        step("rst_regrant");
        chk("rst_regrant_idx0", 16'(if_u.gnt), 16'h0001);
        for (int c = 0; c < 5; c++) step("rst_after");
        req = '0;
        for (int c = 0; c < 3; c++) step("rst_drain");

        // Randomised traffic with hold-overs and drops after grant
        for (int c = 0; c < 400; c++) begin
            step("random");
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ra = rand_operand();
                        set_ops(i, ra, ($urandom_range(0, 3) == 0) ? ra : rand_operand());
                        req[i] = 1'b1;
                    end
                end else if (m_done[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                    if (req[i]) set_ops(i, rand_operand(), rand_operand());
                end else if (m_gnt[i] && $urandom_range(0, 4) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        for (int c = 0; c < 3; c++) step("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
